// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: conditions buttons/switches, runs RUN/PAUSE/ADJ and emits counter strobes.
// Latency: raw input to debounced value 2+DEBOUNCE_CYC cycles; debounced event to registered output 1 cycle.
// Backpressure: none; strobes are single-cycle and unconditional, the counter must accept them every cycle.
module stopwatch_ctrl #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_pause,
    input  logic btn_clr,
    input  logic sw_sel,
    input  logic sw_adj,
    output logic sec_inc,
    output logic sec_adj,
    output logic min_inc,
    output logic cnt_clr,
    output logic paused,
    output logic adj_mode,
    output logic blink
);

    localparam int DW  = $clog2(DEBOUNCE_CYC + 1);
    localparam int D1W = $clog2(CLK_HZ);
    localparam int D2W = $clog2(CLK_HZ / 2);

    localparam logic [DW-1:0]  DEB_LAST  = DW'(DEBOUNCE_CYC - 1);
    localparam logic [D1W-1:0] DIV1_LAST = D1W'(CLK_HZ - 1);
    localparam logic [D2W-1:0] DIV2_LAST = D2W'(CLK_HZ / 2 - 1);

    // Conditioned input lanes: 0 pause, 1 clear, 2 sel, 3 adj
    localparam int N_IN = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAUSE = 2'd1,
        ADJ   = 2'd2
    } state_t;

    logic [N_IN-1:0] raw;
    logic [N_IN-1:0] sync1;
    logic [N_IN-1:0] sync2;
    logic [N_IN-1:0] db;
    logic [N_IN-1:0] db_q;
    logic [DW-1:0]   deb_cnt [N_IN];

    state_t          state;
    logic            saved_pause;
    logic [D1W-1:0]  div1;
    logic [D2W-1:0]  div2;

    logic pause_evt;
    logic clr_evt;
    logic sel_db;
    logic adj_db;
    logic div1_wrap;
    logic div2_wrap;

    assign raw       = {sw_adj, sw_sel, btn_clr, btn_pause};
    assign pause_evt = db[0] & ~db_q[0];
    assign clr_evt   = db[1] & ~db_q[1];
    assign sel_db    = db[2];
    assign adj_db    = db[3];
    assign div1_wrap = (div1 == DIV1_LAST);
    assign div2_wrap = (div2 == DIV2_LAST);

    // Two-flop synchronizers plus the delayed debounced copy used for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            db_q  <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            db_q  <= db;
        end
    end

    // Debouncers: a lane's value only moves after DEBOUNCE_CYC consecutive disagreeing cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db <= '0;
            for (int i = 0; i < N_IN; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (sync2[i] == db[i]) begin
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    if (deb_cnt[i] == DEB_LAST) begin
                        db[i] <= sync2[i];
                    end
                end
            end
        end
    end

    // Mode FSM, tick dividers and registered strobes; clear beats mode change beats pause beats ticks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            saved_pause <= 1'b0;
            div1        <= '0;
            div2        <= '0;
            sec_inc     <= 1'b0;
            sec_adj     <= 1'b0;
            min_inc     <= 1'b0;
            cnt_clr     <= 1'b0;
            paused      <= 1'b0;
            adj_mode    <= 1'b0;
            blink       <= 1'b1;
        end else begin
            sec_inc <= 1'b0;
            sec_adj <= 1'b0;
            min_inc <= 1'b0;
            cnt_clr <= 1'b0;
            if (clr_evt) begin
                cnt_clr <= 1'b1;
                div1    <= '0;
                div2    <= '0;
            end else begin
                // Dividers keep counting in their own state even when a higher-priority
                // event swallows the strobe, so a suppressed tick is dropped, not deferred.
                if (state == RUN) begin
                    div1 <= div1_wrap ? '0 : div1 + 1'b1;
                end
                if (state == ADJ) begin
                    div2 <= div2_wrap ? '0 : div2 + 1'b1;
                end

                if (state != ADJ && adj_db) begin
                    state       <= ADJ;
                    saved_pause <= (state == PAUSE);
                    adj_mode    <= 1'b1;
                    blink       <= 1'b1;
                    div2        <= '0;
                end else if (state == ADJ && !adj_db) begin
                    state    <= saved_pause ? PAUSE : RUN;
                    paused   <= saved_pause;
                    adj_mode <= 1'b0;
                    blink    <= 1'b1;
                end else if (state != ADJ && pause_evt) begin
                    state  <= (state == RUN) ? PAUSE : RUN;
                    paused <= (state == RUN);
                end else begin
                    if (state == RUN && div1_wrap) begin
                        sec_inc <= 1'b1;
                    end
                    if (state == ADJ && div2_wrap) begin
                        blink <= ~blink;
                        if (sel_db) begin
                            sec_adj <= 1'b1;
                        end else begin
                            min_inc <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with CLK_HZ=8 and DEBOUNCE_CYC=4.
// Latency: all expectations are counted in rising edges after reset release.
// Backpressure: not applicable; outputs are sampled 1 ns after each rising edge.
module tb_stopwatch_ctrl;

    logic clk;
    logic rst_n;
    logic btn_pause;
    logic btn_clr;
    logic sw_sel;
    logic sw_adj;
    logic sec_inc;
    logic sec_adj;
    logic min_inc;
    logic cnt_clr;
    logic paused;
    logic adj_mode;
    logic blink;

    int cyc;
    int checks;
    int failures;
    int p;
    int q;
    int a;
    int b;
    int d;

    stopwatch_ctrl #(
        .CLK_HZ      (8),
        .DEBOUNCE_CYC(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_pause(btn_pause),
        .btn_clr  (btn_clr),
        .sw_sel   (sw_sel),
        .sw_adj   (sw_adj),
        .sec_inc  (sec_inc),
        .sec_adj  (sec_adj),
        .min_inc  (min_inc),
        .cnt_clr  (cnt_clr),
        .paused   (paused),
        .adj_mode (adj_mode),
        .blink    (blink)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sec_inc"}, sec_inc, 1'b0);
        chk({tag, "_sec_adj"}, sec_adj, 1'b0);
        chk({tag, "_min_inc"}, min_inc, 1'b0);
        chk({tag, "_cnt_clr"}, cnt_clr, 1'b0);
        chk({tag, "_paused"}, paused, 1'b0);
        chk({tag, "_adj_mode"}, adj_mode, 1'b0);
        chk({tag, "_blink"}, blink, 1'b1);
    endtask

    initial begin
        cyc       = 0;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        btn_pause = 1'b0;
        btn_clr   = 1'b0;
        sw_sel    = 1'b0;
        sw_adj    = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        rst_n = 1'b1;
        cyc   = 0;

        // Free run: sec_inc every 8 cycles starting at cycle 8
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("run_sec_inc", sec_inc, (cyc % 8) == 0);
            chk("run_other", sec_adj | min_inc | cnt_clr, 1'b0);
            chk("run_blink", blink, 1'b1);
            chk("run_paused", paused, 1'b0);
        end

        // Pause press held 10 cycles; paused 7 cycles after press, div1 frozen at 3
        repeat (4) tick();
        p = cyc;
        btn_pause = 1'b1;
        for (int i = 0; i < 26; i++) begin
            tick();
            if (cyc == p + 10) btn_pause = 1'b0;
            chk("pause_paused", paused, cyc >= p + 7);
            chk("pause_sec_inc", sec_inc, cyc == p + 4);
        end

        // Resume press: first sec_inc 5 cycles after paused falls
        q = cyc;
        btn_pause = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (cyc == q + 10) btn_pause = 1'b0;
            chk("resume_paused", paused, cyc < q + 7);
            chk("resume_sec_inc", sec_inc, cyc == q + 12);
        end
        repeat (10) begin
            tick();
            chk("idle_sec_inc", sec_inc, ((cyc - (q + 12)) % 8) == 0);
        end

        // Bouncing pause button: never stable 4 cycles, no event
        for (int i = 0; i < 30; i++) begin
            if (i < 20 && (i % 2) == 0) btn_pause = ~btn_pause;
            tick();
            chk("bounce_paused", paused, 1'b0);
            chk("bounce_sec_inc", sec_inc, ((cyc - (q + 12)) % 8) == 0);
        end
        chk("bounce_btn_low", btn_pause, 1'b0);

        // Adjust mode with sel=0, then sel=1 mid-way, then exit back to RUN
        repeat (6) tick();
        a = cyc;
        sw_adj = 1'b1;
        for (int i = 0; i < 48; i++) begin
            tick();
            if (cyc == a + 16) sw_sel = 1'b1;
            if (cyc == a + 27) sw_adj = 1'b0;
            chk("adj_mode", adj_mode, cyc >= a + 7 && cyc < a + 34);
            chk("adj_min_inc", min_inc, cyc == a + 11 || cyc == a + 15 || cyc == a + 19);
            chk("adj_sec_adj", sec_adj, cyc == a + 23 || cyc == a + 27 || cyc == a + 31);
            chk("adj_sec_inc", sec_inc, cyc == a + 2 || cyc == a + 37 || cyc == a + 45);
            chk("adj_blink", blink,
                !(cyc >= a + 7 && cyc < a + 34 && (((cyc - a - 7) / 4) % 2) == 1));
            chk("adj_paused", paused, 1'b0);
        end

        // Clear event on the div1 wrap cycle: cnt_clr, sec_inc suppressed, restart
        repeat (6) tick();
        b = cyc;
        btn_clr = 1'b1;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (cyc == b + 10) btn_clr = 1'b0;
            chk("clr_cnt_clr", cnt_clr, cyc == b + 7);
            chk("clr_sec_inc", sec_inc, cyc == b + 15 || cyc == b + 23);
            chk("clr_adj_strobes", sec_adj | min_inc, 1'b0);
        end

        // PAUSE -> ADJ, pause press ignored inside ADJ, exit back to PAUSE
        d = cyc;
        btn_pause = 1'b1;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (cyc == d + 8)  btn_pause = 1'b0;
            if (cyc == d + 10) sw_adj = 1'b1;
            if (cyc == d + 20) btn_pause = 1'b1;
            if (cyc == d + 28) btn_pause = 1'b0;
            if (cyc == d + 32) sw_adj = 1'b0;
            chk("padj_paused", paused, cyc >= d + 7);
            chk("padj_mode", adj_mode, cyc >= d + 17 && cyc < d + 39);
            chk("padj_sec_inc", sec_inc, 1'b0);
        end

        // Re-enter ADJ, then asynchronous reset mid-ADJ
        sw_adj = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("radj_mode", adj_mode, cyc >= d + 52);
            chk("radj_blink", blink, cyc < d + 56);
            chk("radj_paused", paused, 1'b1);
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        repeat (2) tick();
        chk_reset_vals("held_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Sequencing controller for the stopwatch seconds/minutes counter. Runs on the single board clock. It synchronizes and debounces the raw pause/clear buttons and the sel/adj switches, and derives the 1 Hz run tick and 2 Hz adjust tick from the board clock. Its output is one-cycle increment/clear strobes to the counter, plus status and blink signals for the display driver. No second clock domain and no derived clocks exist downstream.

## Interface
- CLK_HZ, 100_000_000: board clock cycles per second; must be even and ≥ 4.
- DEBOUNCE_CYC, 1_000_000: consecutive stable cycles required before a debounced input changes.
- clk  in  1  board clock; all state on rising edge.
- rst_n  in  1  one clock; reset is asynchronous and active-low.
- btn_pause  in  1  raw pause button, asynchronous, active-high.
- btn_clr  in  1  raw clear button, asynchronous, active-high.
- sw_sel  in  1  raw switch; 0 = minutes, 1 = seconds.
- sw_adj  in  1  raw switch; 1 = adjust mode.
- sec_inc  out  1  one-cycle strobe: seconds +1 with carry into minutes.
- sec_adj  out  1  one-cycle strobe: seconds +1, wrap 59→0, no carry.
- min_inc  out  1  one-cycle strobe: minutes +1, wrap 59→0.
- cnt_clr  out  1  one-cycle strobe: clear both fields.
- paused  out  1  1 while the run state is PAUSE, including the state saved during ADJ.
- adj_mode  out  1  1 while in ADJ.
- blink  out  1  display enable for the selected field; constant 1 outside ADJ.

## Operation
- Input conditioning, per input:
  - 2-flop synchronizer, then debouncer.
  - Debounce counter clears whenever the synced value equals the debounced value.
  - Otherwise the counter increments; when it reaches DEBOUNCE_CYC the debounced value takes the synced value.
- Button events: a rising edge of debounced btn_pause or btn_clr produces a one-cycle internal event. Holding a button produces no repeat.
- States: RUN, PAUSE, ADJ. A 1-bit saved_run records RUN/PAUSE while in ADJ.
  - RUN → PAUSE: pause event. PAUSE → RUN: pause event.
  - RUN/PAUSE → ADJ: debounced sw_adj = 1. Current state goes to saved_run.
  - ADJ → saved_run state: debounced sw_adj = 0.
  - In ADJ, pause events are ignored.
- div1, range 0..CLK_HZ-1:
  - Increments only in RUN; held in PAUSE and ADJ, so a partial second is retained.
  - On the RUN cycle where div1 = CLK_HZ-1: wraps to 0 and asserts sec_inc.
- div2, range 0..CLK_HZ/2-1:
  - Cleared on ADJ entry; increments only in ADJ.
  - On wrap: toggles blink and asserts sec_adj if debounced sw_sel = 1, else min_inc.
- blink: forced to 1 on ADJ entry, toggles on each div2 wrap, forced to 1 outside ADJ.
- Clear event, any state:
  - Asserts cnt_clr and clears div1 and div2.
  - State, saved_run and blink are unchanged.
- Priority within one cycle: clear event > ADJ entry/exit > pause event > tick strobes.
  - A suppressed tick is lost and not deferred.
- At most one of sec_inc, sec_adj, min_inc, cnt_clr is high in any cycle.
- A sw_sel change in ADJ affects the next div2 wrap only; div2 and blink are not disturbed.

## Timing
- Reset values:
  - State RUN, saved_run RUN.
  - div1 = div2 = 0; all debounced values and debounce counters 0.
  - sec_inc = sec_adj = min_inc = cnt_clr = 0; paused = 0; adj_mode = 0; blink = 1.
- Reset assertion forces all reset values immediately, mid-operation included. After deassertion the first state change occurs at a clock edge.
- Debounce latency: raw change to debounced change = 2 + DEBOUNCE_CYC cycles when the input is stable throughout.
  - Any bounce shorter than DEBOUNCE_CYC is filtered.
- Debounced button rise → event → state/strobe registered on the following edge, visible 1 cycle after the debounced change.
- All outputs are registered. Strobes are exactly 1 cycle wide.
- sec_inc period in continuous RUN: exactly CLK_HZ cycles.
  - The first sec_inc after reset comes CLK_HZ cycles after the first RUN cycle.
- First adjust strobe: CLK_HZ/2 cycles after adj_mode rises; then every CLK_HZ/2 cycles.
- After cnt_clr in RUN, the next sec_inc comes CLK_HZ cycles later.
- paused and adj_mode change in the same cycle as the state register.

## Test plan
Test parameters: CLK_HZ = 8, DEBOUNCE_CYC = 4.
- Reset, all inputs 0, 40 cycles → sec_inc pulses at cycles 8, 16, 24, 32, 40 after release; other strobes 0; blink = 1.
- btn_pause high for 10 cycles at div1 = 3 → paused = 1 after 2+4+1 cycles, no sec_inc while paused; second press → first sec_inc 5 cycles after paused falls.
- Bounce: btn_pause toggled every 2 cycles for 20 cycles, then low → no pause event, paused stays 0.
- sw_adj = 1 with sw_sel = 0 → adj_mode rises; min_inc every 4 cycles; blink toggles every 4 cycles. Set sw_sel = 1 mid-way → next wrap gives sec_adj. sw_adj = 0 → returns to RUN with div1 resumed.
- Clear event landing on the div1 = 7 cycle → cnt_clr high, sec_inc suppressed, next sec_inc 8 cycles later.
- Enter ADJ from PAUSE; press pause inside ADJ; exit → paused = 1 throughout, state PAUSE. Assert rst_n = 0 mid-ADJ → all outputs at reset values without a clock edge.
